// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR pattern source: maximal-length tap masks for widths 3..16
// and the default seed.
package lfsr_pkg;

    localparam int unsigned LFSR_MIN_WIDTH = 3;
    localparam int unsigned LFSR_MAX_WIDTH = 16;
    localparam logic [15:0] DEFAULT_SEED   = 16'h0001;

    // Bit i set means state[i] feeds the XOR; every entry gives a 2^w-1 period.
    function automatic logic [15:0] taps_for(input int unsigned width);
        logic [15:0] mask;
        mask = 16'h0000;
        case (width)
            3:       mask = 16'h0006;
            4:       mask = 16'h000C;
            5:       mask = 16'h0014;
            6:       mask = 16'h0030;
            7:       mask = 16'h0060;
            8:       mask = 16'h00B8;
            9:       mask = 16'h0110;
            10:      mask = 16'h0240;
            11:      mask = 16'h0500;
            12:      mask = 16'h0E08;
            13:      mask = 16'h1C80;
            14:      mask = 16'h3802;
            15:      mask = 16'h6000;
            16:      mask = 16'hD008;
            default: mask = 16'h0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/lfsr_if.sv
// Output bundle of the LFSR pattern source; the master modport is the generator side.
// Building with LFSR_SEED_LOAD_EN adds the seed-load inputs.
interface lfsr_if #(
    parameter int unsigned WIDTH = 8
);
    logic             o_randomBit;
    logic [WIDTH-1:0] o_state;
    logic             o_periodDone;
`ifdef LFSR_SEED_LOAD_EN
    logic             i_load;
    logic [WIDTH-1:0] i_seed;
`endif

    modport master (
        output o_randomBit, o_state, o_periodDone
`ifdef LFSR_SEED_LOAD_EN
        , input i_load, i_seed
`endif
    );

    modport slave (
        input o_randomBit, o_state, o_periodDone
`ifdef LFSR_SEED_LOAD_EN
        , output i_load, i_seed
`endif
    );
endinterface

// File: rtl/lfsr_core.sv
// Fibonacci LFSR state register: shifts toward the MSB with XOR feedback into bit 0.
// An all-zero state reloads SEED; LFSR_SEED_LOAD_EN adds a synchronous seed load.
module lfsr_core #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = '1,
    parameter logic [WIDTH-1:0] SEED  = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
`ifdef LFSR_SEED_LOAD_EN
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_seed,
`endif
    output logic [WIDTH-1:0] o_state
);

    logic [WIDTH-1:0] state_q;
    logic             fb;

    assign fb      = ^(state_q & TAPS);
    assign o_state = state_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= SEED;
        end else begin
`ifdef LFSR_SEED_LOAD_EN
            if (i_load) begin
                // A zero seed would lock the register, so fall back to SEED.
                state_q <= (i_seed == '0) ? SEED : i_seed;
            end else
`endif
            if (state_q == '0) begin
                state_q <= SEED;
            end else begin
                state_q <= {state_q[WIDTH-2:0], fb};
            end
        end
    end

endmodule

// File: rtl/lfsr_test.sv
// Free-running LFSR noise source with serial bit, full state and a once-per-period marker.
// Optional seed load is compiled in with LFSR_SEED_LOAD_EN.
module lfsr_test
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(taps_for(WIDTH)),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEFAULT_SEED)
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    lfsr_if.master bus
);

    if (WIDTH < LFSR_MIN_WIDTH || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
        $error("lfsr_test: WIDTH must be within 3..16");
    end
    if (SEED == '0) begin : g_bad_seed
        $error("lfsr_test: SEED must be non-zero");
    end

    logic [WIDTH-1:0] state;
    logic             left_seed;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
`ifdef LFSR_SEED_LOAD_EN
        .i_load  (bus.i_load),
        .i_seed  (bus.i_seed),
`endif
        .o_state (state)
    );

    // Set by the first shift after reset or load, so the initial SEED is not a period mark.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            left_seed <= 1'b0;
        end else begin
`ifdef LFSR_SEED_LOAD_EN
            if (bus.i_load) begin
                left_seed <= 1'b0;
            end else
`endif
            left_seed <= 1'b1;
        end
    end

    assign bus.o_state      = state;
    assign bus.o_randomBit  = state[WIDTH-1];
    assign bus.o_periodDone = left_seed && (state == SEED);

endmodule

// File: tb/tb_lfsr_test.sv
// Self-checking bench for lfsr_test (WIDTH=8): randomized run lengths, async resets and
// loads compared against an arithmetic reference of the LFSR sequence.
module tb_lfsr_test;

    localparam int W      = 8;
    localparam int M_SEED = 1;
    localparam int M_TAPS = 'hB8;
    localparam int M_MASK = (1 << W) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    lfsr_if #(.WIDTH(W)) bus();

    lfsr_test #(.WIDTH(W)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int m_state;
    int m_steps;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_of(input int s);
        int fb;
        if (s == 0) return M_SEED;
        fb = $countones(s & M_TAPS) % 2;
        return ((s * 2) + fb) & M_MASK;
    endfunction

    function automatic int exp_pd();
        return (m_state == M_SEED && m_steps > 0) ? 1 : 0;
    endfunction

    task automatic model_reset();
        m_state = M_SEED;
        m_steps = 0;
    endtask

    // One clock: advance the model and compare state, serial bit and period marker.
    task automatic step_check(input string tag);
        @(posedge clk);
        #1;
        m_state = next_of(m_state);
        m_steps++;
        check({tag, "_state"}, 32'(bus.o_state), 32'(m_state));
        check({tag, "_bit"}, 32'(bus.o_randomBit), 32'((m_state >> (W - 1)) & 1));
        check({tag, "_pd"}, 32'(bus.o_periodDone), 32'(exp_pd()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses[$];
        bit seen[256];
        int distinct;
        int p0, p1;
        int toggles;
        logic prev_bit;
        logic [2:0] dbuf, mbuf;

`ifdef LFSR_SEED_LOAD_EN
        bus.i_load = 1'b0;
        bus.i_seed = '0;
`endif
        model_reset();

        // Reset state while held.
        #12;
        check("rst_state", 32'(bus.o_state), 32'h01);
        check("rst_bit", 32'(bus.o_randomBit), 32'h0);
        check("rst_pd", 32'(bus.o_periodDone), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_state", 32'(bus.o_state), 32'h01);

        // Two full periods: marker at 255 and 510, all states distinct within a period.
        distinct = 0;
        for (int c = 1; c <= 510; c++) begin
            step_check("period");
            if (bus.o_periodDone) pulses.push_back(c);
            if (c <= 255 && !seen[bus.o_state]) begin
                seen[bus.o_state] = 1'b1;
                distinct++;
            end
            if (c == 7) begin
                check("seq7_state", 32'(bus.o_state), 32'h8E);
                check("seq7_bit", 32'(bus.o_randomBit), 32'h1);
            end
            if (c == 255) check("c255_state", 32'(bus.o_state), 32'h01);
        end
        p0 = (pulses.size() > 0) ? pulses[0] : -1;
        p1 = (pulses.size() > 1) ? pulses[1] : -1;
        check("pd_count", 32'(pulses.size()), 32'd2);
        check("pd_first", 32'(p0), 32'd255);
        check("pd_second", 32'(p1), 32'd510);
        check("distinct", 32'(distinct), 32'd255);

        // Serial stream grouped into 3-bit words, one capture every 4 clocks.
        dbuf = '0;
        mbuf = '0;
        for (int c = 1; c <= 1000; c++) begin
            @(posedge clk);
            #1;
            m_state = next_of(m_state);
            m_steps++;
            dbuf = {dbuf[1:0], bus.o_randomBit};
            mbuf = {mbuf[1:0], m_state[W-1]};
            if (c % 4 == 0) check("word", 32'(dbuf), 32'(mbuf));
        end

        // Asynchronous reset between edges at random points in the sequence.
        repeat (4) begin
            int n;
            n = $urandom_range(3, 60);
            repeat (n) step_check("pre_arst");
            #2;
            rst_n = 1'b0;
            #1;
            check("arst_state", 32'(bus.o_state), 32'h01);
            check("arst_pd", 32'(bus.o_periodDone), 32'h0);
            model_reset();
            @(negedge clk);
            rst_n = 1'b1;
            step_check("restart");
            check("restart_02", 32'(bus.o_state), 32'h02);
            step_check("restart");
            check("restart_04", 32'(bus.o_state), 32'h04);
        end

        // Lock-up recovery from a forced all-zero state.
        repeat ($urandom_range(5, 30)) step_check("pre_zero");
        @(negedge clk);
        force dut.u_core.state_q = '0;
        #1;
        check("zero_forced", 32'(bus.o_state), 32'h0);
        release dut.u_core.state_q;
        m_state = 0;
        step_check("zero_recover");
        check("zero_to_seed", 32'(bus.o_state), 32'h01);
        toggles = 0;
        prev_bit = bus.o_randomBit;
        repeat (24) begin
            step_check("post_zero");
            if (bus.o_randomBit != prev_bit) toggles++;
            prev_bit = bus.o_randomBit;
        end
        check("not_stuck", 32'(toggles > 0), 32'h1);

`ifdef LFSR_SEED_LOAD_EN
        // Directed loads, then a few random ones (zero seeds included).
        for (int k = 0; k < 10; k++) begin
            int sd;
            sd = (k == 0) ? 'h5A : (k == 1) ? 0 : ((k % 4 == 0) ? 0 : int'($urandom_range(0, 255)));
            bus.i_load = 1'b1;
            bus.i_seed = W'(sd);
            @(posedge clk);
            #1;
            bus.i_load = 1'b0;
            m_state = (sd == 0) ? M_SEED : sd;
            m_steps = 0;
            check("load_state", 32'(bus.o_state), 32'(m_state));
            check("load_pd", 32'(bus.o_periodDone), 32'h0);
            if (k == 0) check("load_5a", 32'(bus.o_state), 32'h5A);
            if (k == 1) check("load_zero", 32'(bus.o_state), 32'h01);
            repeat ($urandom_range(1, 12)) step_check("after_load");
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
